txt_mem_arbiter: RTL and testbench
==================================

Name: txt_mem_arbiter

Overview:
- Owns the single-port text display memory: 8-bit character codes, 40x30 cells, synchronous read.
- Shares that memory between three users:
  - the text renderer's character fetch (read);
  - CPU character writes, buffered in a small FIFO;
  - an internal clear-screen sequencer.
- Sits between the renderer, the CPU bus bridge and the display memory block.
- Guarantees the renderer is never stalled.

Parameters:
- COLS, 40, characters per row.
- ROWS, 30, character rows.
- FIFO_DEPTH, 4, CPU write FIFO entries (power of two, >=2).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- gpu_req  in  1  renderer fetch request, one-cycle pulse.
- gpu_addr  in  12  renderer cell address.
- gpu_data  out  8  fetched character code.
- gpu_valid  out  1  gpu_data valid, one-cycle pulse.
- cpu_wr_valid  in  1  CPU write request.
- cpu_wr_ready  out  1  FIFO can accept.
- cpu_wr_addr  in  12  CPU cell address.
- cpu_wr_data  in  8  CPU character code.
- cpu_oor  out  1  pulse: an accepted write was dropped for being out of range.
- clr_start  in  1  pulse: start clear-screen.
- clr_char  in  8  fill character, sampled at clr_start.
- clr_busy  out  1  clear in progress.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  12  memory address.
- mem_wdata  out  8  memory write data.
- mem_rdata  in  8  memory read data, one cycle after mem_en with mem_we=0.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - mem_en, mem_we, gpu_valid, cpu_oor, clr_busy = 0.
  - mem_addr, mem_wdata, gpu_data = 0.
  - FIFO empty; clear FSM in IDLE.
  - cpu_wr_ready = 1 in the first cycle after reset deasserts.
- Reset mid-clear or with FIFO occupied: clear aborts, pending writes are discarded, no memory access is issued in the reset cycle.
- Memory ports (mem_*) are registered: a grant decided in cycle N drives mem_* in cycle N+1.
- Priority each cycle, fixed:
  - 1st: gpu_req.
  - 2nd: clear sequencer (clr_busy).
  - 3rd: FIFO head (FIFO not empty).
  - Otherwise mem_en=0 and mem_we=0.
- Renderer read:
  - gpu_req in cycle N -> mem_en=1, mem_we=0, mem_addr=gpu_addr in N+1.
  - gpu_valid=1 with gpu_data=mem_rdata in N+2; gpu_data holds its value until the next fetch.
  - Back-to-back gpu_req is legal; latency stays 2 regardless of clear or FIFO activity.
- CPU write FIFO:
  - cpu_wr_ready = !full && !clr_busy.
  - Push on cpu_wr_valid && cpu_wr_ready.
  - Pop when granted.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
  - When full, ready stays low even if a pop happens that cycle (ready is registered from occupancy).
- Range check, at pop:
  - Address >= COLS*ROWS (1200): no memory write; cpu_oor pulses for 1 cycle; the entry is consumed.
  - Valid address: mem_en=1, mem_we=1, mem_addr/mem_wdata from the entry.
- Clear FSM states: IDLE, CLEAR.
  - IDLE + clr_start -> CLEAR. Latch clr_char, counter = 0, clr_busy = 1 in the next cycle.
  - In CLEAR, each non-gpu_req cycle writes the latched char to the counter address and increments the counter.
  - After writing address 1199 -> IDLE, clr_busy = 0 in the next cycle.
  - clr_start while in CLEAR is ignored.
  - An uncontended clear takes exactly 1200 write cycles.
- FIFO entries accepted before clr_start are held, not dropped, and drain after the clear completes (they overwrite the fill).
- Address arithmetic: cells are addressed as row*COLS+col. The block only bounds-checks and does not compute the address.

Decomposition:
- Shared package txt_pkg:
  - TXT_COLS=40, TXT_ROWS=30, TXT_CHARS=1200.
  - TXT_ADDR_W=12, TXT_DATA_W=8.
  - Clear-FSM state enum.
- One sub-module, txt_wr_fifo: synchronous FIFO with parameters width 20 and depth FIFO_DEPTH; full, empty, push, pop; synchronous active-high reset.

Test Plan:
- Reset released with memory model preloaded (addr 5 = 0x41), then gpu_req with gpu_addr=5 -> mem read at addr 5 one cycle later; gpu_valid with gpu_data=0x41 exactly 2 cycles after the request.
- CPU writes (10,0x31), (11,0x32), with no gpu_req -> two mem writes in order, each one cycle after push; a read of addr 11 returns 0x32.
- 5 back-to-back CPU writes while gpu_req is held high, FIFO_DEPTH=4 -> cpu_wr_ready drops after the 4th push; no writes while gpu_req=1; all 4 drain in order after gpu_req drops; the 5th write is accepted once ready rises.
- CPU write to addr 1200 -> entry accepted, no mem write, cpu_oor pulses once.
- clr_start with clr_char=0x20 and a gpu_req every 8th cycle -> clr_busy high until 1200 writes of 0x20 (addresses 0..1199) have been issued; all reads still return on the 2-cycle latency; clr_start mid-clear is ignored.
- reset asserted 100 cycles into a clear with 2 FIFO entries pending -> next cycle clr_busy=0, no mem activity, FIFO empty, cpu_wr_ready=1.

Source files
------------

// File: rtl/txt_pkg.sv
// Shared constants, clear-FSM state and CPU write-entry layout for the text memory arbiter.
package txt_pkg;
  localparam int TXT_COLS   = 40;
  localparam int TXT_ROWS   = 30;
  localparam int TXT_CHARS  = TXT_COLS * TXT_ROWS;
  localparam int TXT_ADDR_W = 12;
  localparam int TXT_DATA_W = 8;

  typedef enum logic {
    CLR_IDLE,
    CLR_CLEAR
  } clr_state_t;

  typedef struct packed {
    logic [TXT_ADDR_W-1:0] addr;
    logic [TXT_DATA_W-1:0] data;
  } wr_ent_t;
endpackage

// File: rtl/txt_wr_fifo.sv
// Synchronous FIFO for buffered CPU character writes.
// Latency: pushed entry visible at head the next cycle.
// Backpressure: caller must not push when full nor pop when empty.
module txt_wr_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset so it can map onto plain register-file cells.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
endmodule

// File: rtl/txt_mem_arbiter.sv
// Arbitrates the single-port text memory between renderer fetch, clear sequencer and CPU write FIFO.
// Latency: grant -> mem_* next cycle; gpu_req -> gpu_valid exactly 2 cycles later.
// Backpressure: cpu_wr_ready low when FIFO full or clearing; renderer is never stalled.
module txt_mem_arbiter
  import txt_pkg::*;
#(
  parameter int COLS       = TXT_COLS,
  parameter int ROWS       = TXT_ROWS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  gpu_req,
  input  logic [TXT_ADDR_W-1:0] gpu_addr,
  output logic [TXT_DATA_W-1:0] gpu_data,
  output logic                  gpu_valid,
  input  logic                  cpu_wr_valid,
  output logic                  cpu_wr_ready,
  input  logic [TXT_ADDR_W-1:0] cpu_wr_addr,
  input  logic [TXT_DATA_W-1:0] cpu_wr_data,
  output logic                  cpu_oor,
  input  logic                  clr_start,
  input  logic [TXT_DATA_W-1:0] clr_char,
  output logic                  clr_busy,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [TXT_ADDR_W-1:0] mem_addr,
  output logic [TXT_DATA_W-1:0] mem_wdata,
  input  logic [TXT_DATA_W-1:0] mem_rdata
);
  localparam logic [TXT_ADDR_W-1:0] ADDR_LIMIT = TXT_ADDR_W'(COLS * ROWS);
  localparam logic [TXT_ADDR_W-1:0] LAST_ADDR  = TXT_ADDR_W'(COLS * ROWS - 1);

  clr_state_t            state, state_nxt;
  logic [TXT_ADDR_W-1:0] clr_cnt;
  logic [TXT_DATA_W-1:0] clr_fill;
  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
  wr_ent_t               fifo_in, fifo_head;
  logic                  gnt_clr, gnt_fifo, head_oor, rd_issue;
  logic [TXT_DATA_W-1:0] gpu_data_hold;

  // Ready looks only at registered occupancy, so a pop cannot reopen a full FIFO that cycle.
  assign cpu_wr_ready = !fifo_full && !clr_busy;
  assign fifo_push    = cpu_wr_valid && cpu_wr_ready;
  assign fifo_in      = {cpu_wr_addr, cpu_wr_data};
  assign gnt_clr      = clr_busy && !gpu_req;
  assign gnt_fifo     = !gpu_req && !clr_busy && !fifo_empty;
  assign fifo_pop     = gnt_fifo;
  assign head_oor     = (fifo_head.addr >= ADDR_LIMIT);

  txt_wr_fifo #(
    .WIDTH ($bits(wr_ent_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_dat (fifo_in),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= CLR_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLR_IDLE:  if (clr_start) state_nxt = CLR_CLEAR;
      CLR_CLEAR: if (gnt_clr && clr_cnt == LAST_ADDR) state_nxt = CLR_IDLE;
      default:   state_nxt = CLR_IDLE;
    endcase
  end

  always_comb begin
    clr_busy = (state == CLR_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_cnt  <= '0;
      clr_fill <= '0;
    end else if (state == CLR_IDLE && clr_start) begin
      clr_cnt  <= '0;
      clr_fill <= clr_char;
    end else if (gnt_clr) begin
      clr_cnt  <= clr_cnt + TXT_ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en        <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      cpu_oor       <= 1'b0;
      rd_issue      <= 1'b0;
      gpu_valid     <= 1'b0;
      gpu_data_hold <= '0;
    end else begin
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      cpu_oor  <= 1'b0;
      rd_issue <= 1'b0;
      if (gpu_req) begin
        mem_en   <= 1'b1;
        mem_addr <= gpu_addr;
        rd_issue <= 1'b1;
      end else if (gnt_clr) begin
        mem_en    <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= clr_cnt;
        mem_wdata <= clr_fill;
      end else if (gnt_fifo) begin
        if (head_oor) begin
          cpu_oor <= 1'b1;
        end else begin
          mem_en    <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= fifo_head.addr;
          mem_wdata <= fifo_head.data;
        end
      end
      gpu_valid <= rd_issue;
      if (gpu_valid) gpu_data_hold <= mem_rdata;
    end
  end

  // Read data passes straight through on the return cycle, then is held.
  assign gpu_data = gpu_valid ? mem_rdata : gpu_data_hold;
endmodule

// File: tb/tb_txt_mem_arbiter.sv
// Randomized bench for txt_mem_arbiter: queue-based reference model plus directed literal checks.
module tb_txt_mem_arbiter;
  localparam int DEPTH = 4;
  localparam int CHARS = 1200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        gpu_req = 1'b0;
  logic [11:0] gpu_addr = '0;
  logic [7:0]  gpu_data;
  logic        gpu_valid;
  logic        cpu_wr_valid = 1'b0;
  logic        cpu_wr_ready;
  logic [11:0] cpu_wr_addr = '0;
  logic [7:0]  cpu_wr_data = '0;
  logic        cpu_oor;
  logic        clr_start = 1'b0;
  logic [7:0]  clr_char = '0;
  logic        clr_busy;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  txt_mem_arbiter #(.COLS(40), .ROWS(30), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .gpu_req(gpu_req), .gpu_addr(gpu_addr), .gpu_data(gpu_data), .gpu_valid(gpu_valid),
    .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready),
    .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data), .cpu_oor(cpu_oor),
    .clr_start(clr_start), .clr_char(clr_char), .clr_busy(clr_busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Display memory attached to the DUT, plus an independent reference copy.
  logic [7:0] bmem    [0:4095];
  logic [7:0] ref_mem [0:4095];

  initial begin
    for (int i = 0; i < 4096; i++) begin
      bmem[i]    = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    bmem[5]    = 8'h41;
    ref_mem[5] = 8'h41;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bmem[mem_addr] <= mem_wdata;
      else        mem_rdata      <= bmem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, clear as an index, reads as a 2-stage return.
  typedef struct {
    logic [11:0] a;
    logic [7:0]  d;
  } ent_t;

  ent_t        q[$];
  bit          model_ok = 0;
  bit          m_clr;
  int          m_idx;
  logic [7:0]  m_ch;
  bit          rd_stage;
  logic [7:0]  rd_stage_d;
  bit          e_en, e_we, e_oor, e_valid, e_busy, e_ready;
  logic [11:0] e_addr;
  logic [7:0]  e_wdata, e_gdata;

  always @(posedge clk) begin
    ent_t hd;
    ent_t nw;
    bit   clr_was;
    bit   can_push;
    if (reset) begin
      q.delete();
      m_clr = 0; m_idx = 0; m_ch = 0; rd_stage = 0;
      e_en = 0; e_we = 0; e_oor = 0; e_valid = 0; e_busy = 0; e_ready = 1;
      e_addr = 0; e_wdata = 0; e_gdata = 0;
      model_ok = 1;
    end else if (model_ok) begin
      clr_was  = m_clr;
      can_push = cpu_wr_valid && (q.size() < DEPTH) && !m_clr;
      e_valid  = rd_stage;
      if (rd_stage) e_gdata = rd_stage_d;
      rd_stage = 0;
      e_en = 0; e_we = 0; e_oor = 0;
      if (gpu_req) begin
        e_en = 1; e_addr = gpu_addr;
        rd_stage = 1; rd_stage_d = ref_mem[gpu_addr];
      end else if (m_clr) begin
        e_en = 1; e_we = 1; e_addr = 12'(m_idx); e_wdata = m_ch;
        ref_mem[m_idx] = m_ch;
        m_idx++;
        if (m_idx == CHARS) m_clr = 0;
      end else if (q.size() > 0) begin
        hd = q.pop_front();
        if (hd.a >= CHARS) e_oor = 1;
        else begin
          e_en = 1; e_we = 1; e_addr = hd.a; e_wdata = hd.d;
          ref_mem[hd.a] = hd.d;
        end
      end
      if (can_push) begin
        nw.a = cpu_wr_addr; nw.d = cpu_wr_data;
        q.push_back(nw);
      end
      if (clr_start && !clr_was) begin
        m_clr = 1; m_idx = 0; m_ch = clr_char;
      end
      e_busy  = m_clr;
      e_ready = (q.size() < DEPTH) && !m_clr;
    end
  end

  always @(posedge clk) begin
    #1;
    if (model_ok) begin
      chk("mem_en", mem_en, e_en);
      chk("mem_we", mem_we, e_we);
      if (e_en) chk("mem_addr", mem_addr, e_addr);
      if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
      chk("cpu_oor", cpu_oor, e_oor);
      chk("gpu_valid", gpu_valid, e_valid);
      chk("gpu_data", gpu_data, e_gdata);
      chk("clr_busy", clr_busy, e_busy);
      chk("cpu_wr_ready", cpu_wr_ready, e_ready);
    end
  end

  task automatic read_check(input logic [11:0] a, input logic [7:0] exp, input string name);
    gpu_req = 1; gpu_addr = a;
    @(negedge clk);
    gpu_req = 0;
    chk({name, "_issue_en"}, mem_en, 1);
    chk({name, "_issue_we"}, mem_we, 0);
    chk({name, "_issue_addr"}, mem_addr, a);
    @(negedge clk);
    chk({name, "_valid"}, gpu_valid, 1);
    chk({name, "_data"}, gpu_data, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int  oor_cnt;
    int  wr_cnt;
    bit  done;

    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_gpu_valid", gpu_valid, 0);
    chk("rst_gpu_data", gpu_data, 0);
    chk("rst_cpu_oor", cpu_oor, 0);
    chk("rst_clr_busy", clr_busy, 0);
    chk("rst_ready", cpu_wr_ready, 1);

    read_check(12'd5, 8'h41, "rd5");

    // Two CPU writes: each lands in mem one cycle after its push cycle
    cpu_wr_valid = 1; cpu_wr_addr = 12'd10; cpu_wr_data = 8'h31;
    @(negedge clk);
    cpu_wr_addr = 12'd11; cpu_wr_data = 8'h32;
    @(negedge clk);
    cpu_wr_valid = 0;
    chk("wr10_we", mem_we, 1);
    chk("wr10_addr", mem_addr, 10);
    chk("wr10_data", mem_wdata, 8'h31);
    @(negedge clk);
    chk("wr11_we", mem_we, 1);
    chk("wr11_addr", mem_addr, 11);
    chk("wr11_data", mem_wdata, 8'h32);
    @(negedge clk);
    read_check(12'd11, 8'h32, "rd11");

    // Fill the FIFO while the renderer hogs the memory
    gpu_req = 1; cpu_wr_valid = 1;
    for (int i = 0; i < 4; i++) begin
      gpu_addr = 12'(300 + i);
      cpu_wr_addr = 12'(200 + i); cpu_wr_data = 8'(8'h60 + i);
      @(negedge clk);
    end
    chk("full_ready_low", cpu_wr_ready, 0);
    cpu_wr_addr = 12'd204; cpu_wr_data = 8'h64;
    for (int k = 0; k < 6; k++) begin
      gpu_addr = 12'(310 + k);
      @(negedge clk);
      chk("hold_no_write", mem_we, 0);
      chk("hold_ready_low", cpu_wr_ready, 0);
    end
    gpu_req = 0;
    for (int k = 0; k < 20 && !cpu_wr_ready; k++) @(negedge clk);
    chk("ready_rise", cpu_wr_ready, 1);
    @(negedge clk);
    cpu_wr_valid = 0;
    repeat (8) @(negedge clk);
    read_check(12'd204, 8'h64, "rd204");

    // Out-of-range write is consumed with a single oor pulse
    cpu_wr_valid = 1; cpu_wr_addr = 12'd1200; cpu_wr_data = 8'h77;
    chk("oor_accept_ready", cpu_wr_ready, 1);
    @(negedge clk);
    cpu_wr_valid = 0;
    oor_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (cpu_oor) oor_cnt++;
      if (mem_we) oor_cnt += 100;
    end
    chk("oor_pulses", oor_cnt, 1);

    // Full clear with periodic renderer fetches and an ignored restart
    clr_char = 8'h20; clr_start = 1;
    @(negedge clk);
    clr_start = 0;
    chk("clr_busy_rise", clr_busy, 1);
    chk("clr_ready_low", cpu_wr_ready, 0);
    wr_cnt = 0; done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      gpu_req  = (c % 8 == 0);
      gpu_addr = 12'($urandom_range(0, 1199));
      if (c == 50) begin clr_start = 1; clr_char = 8'h55; end
      else begin clr_start = 0; clr_char = 8'h20; end
      @(negedge clk);
      if (mem_en && mem_we && mem_wdata == 8'h20) wr_cnt++;
      if (!clr_busy) done = 1;
    end
    gpu_req = 0; clr_start = 0;
    chk("clr_done", done, 1);
    chk("clr_writes", wr_cnt, 1200);
    read_check(12'd1199, 8'h20, "rd_fill_last");

    // Reset in the middle of a clear with two writes pending
    gpu_req = 1; gpu_addr = 12'd7; cpu_wr_valid = 1;
    cpu_wr_addr = 12'd400; cpu_wr_data = 8'hA0;
    @(negedge clk);
    cpu_wr_addr = 12'd401; cpu_wr_data = 8'hA1;
    @(negedge clk);
    cpu_wr_valid = 0; clr_start = 1; clr_char = 8'h2E;
    @(negedge clk);
    clr_start = 0; gpu_req = 0;
    repeat (100) @(negedge clk);
    chk("pre_rst_busy", clr_busy, 1);
    reset = 1;
    @(negedge clk);
    chk("midrst_busy", clr_busy, 0);
    chk("midrst_en", mem_en, 0);
    chk("midrst_we", mem_we, 0);
    chk("midrst_ready", cpu_wr_ready, 1);
    reset = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_idle", mem_en, 0);
    end

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      gpu_req      = ($urandom_range(0, 9) < 3);
      gpu_addr     = 12'($urandom_range(0, 1199));
      cpu_wr_valid = $urandom_range(0, 1) == 1;
      cpu_wr_addr  = 12'($urandom_range(0, 1300));
      cpu_wr_data  = 8'($urandom);
      clr_start    = (c == 300) || ($urandom_range(0, 999) == 0);
      clr_char     = 8'($urandom);
      @(negedge clk);
    end
    gpu_req = 0; cpu_wr_valid = 0; clr_start = 0;
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
